// File: rtl/led_breath_fader.sv
// Eight-channel LED fader: each channel's PWM duty ramps one LSB per step tick
// toward full on or full off, or snaps to its target when fading is disabled.
module led_breath_fader #(
    parameter int unsigned STEP_DIV = 97_656
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] led_in,
    input  logic       en,
    output logic [7:0] led_out,
    output logic       busy
);

    localparam logic [23:0] STEP_LAST = 24'(STEP_DIV - 1);
    localparam logic [7:0]  PWM_LAST  = 8'd254;

    logic [7:0]  in_q;
    logic [7:0]  pwm_cnt;
    logic [23:0] step_cnt;
    logic        step_tick;

    logic [7:0]  duty      [8];
    logic [7:0]  duty_next [8];
    logic [7:0]  target    [8];
    logic [7:0]  led_next;
    logic        busy_next;

    // With STEP_DIV=1 the counter sits at 0 and every cycle is a tick.
    assign step_tick = (step_cnt == STEP_LAST);

    // NOTE: sequential state is always assigned with <=, so every flop samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_q     <= 8'd0;
            pwm_cnt  <= 8'd0;
            step_cnt <= 24'd0;
        end else begin
            in_q     <= led_in;
            pwm_cnt  <= (pwm_cnt == PWM_LAST) ? 8'd0 : pwm_cnt + 8'd1;
            step_cnt <= step_tick ? 24'd0 : step_cnt + 24'd1;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        busy_next = 1'b0;
        led_next  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            target[i]    = {8{in_q[i]}};
            duty_next[i] = duty[i];
            if (!en) begin
                duty_next[i] = target[i];
            end else if (step_tick) begin
                // The comparisons themselves keep the ramp from wrapping at 0 or 255.
                if (duty[i] < target[i]) begin
                    duty_next[i] = duty[i] + 8'd1;
                end else if (duty[i] > target[i]) begin
                    duty_next[i] = duty[i] - 8'd1;
                end
            end
            led_next[i] = (duty[i] > pwm_cnt);
            busy_next   = busy_next | (duty[i] != target[i]);
        end
    end

    // NOTE: duty is a small array of flops rather than a RAM, so it can and does
    // take the reset; a true memory would be left unreset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                duty[i] <= 8'd0;
            end
            led_out <= 8'd0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                duty[i] <= duty_next[i];
            end
            led_out <= led_next;
            busy    <= busy_next;
        end
    end

endmodule

// File: tb/tb_led_breath_fader.sv
// Scoreboard bench for led_breath_fader: stimulus queues hand-derived expected
// led_out/busy per cycle, a monitor pops and compares after every clock edge.
module tb_led_breath_fader;

    logic       clk;
    logic       rstn;
    logic [7:0] led_in;
    logic       en;
    logic [7:0] led_out;
    logic       busy;

    led_breath_fader #(.STEP_DIV(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .led_in  (led_in),
        .en      (en),
        .led_out (led_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] led;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   r_base   = 0;

    localparam int SC_UP  = 0;
    localparam int SC_REV = 1;
    localparam int SC_SW  = 2;

    task automatic push(input int c, input logic [7:0] l, input logic b, input string nm);
        exp_t e;
        e.cyc  = c;
        e.led  = l;
        e.busy = b;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input int c, input logic [7:0] l_act, input logic b_act,
                         input logic [7:0] l_exp, input logic b_exp);
        n_checks++;
        if (l_act !== l_exp || b_act !== b_exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got led_out=%h busy=%b, expected led_out=%h busy=%b",
                     nm, c, l_act, b_act, l_exp, b_exp);
        end
    endtask

    // Edge counter plus comparison of everything queued for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d was never sampled", e.name, e.cyc);
                end else begin
                    check(e.name, cyc, led_out, busy, e.led, e.busy);
                end
            end
        end
    end

    // Duty of channel 0 after edge base+k, derived from the scenario timelines
    // (ticks land on edges base+4m because the step counter is cleared by reset).
    function automatic int exp_duty(input int sc, input int k);
        int d;
        case (sc)
            SC_UP:   d = (k / 4 > 255) ? 255 : k / 4;
            SC_REV:  if (k <= 400) d = k / 4;
                     else d = ((k - 400) / 4 >= 100) ? 0 : 100 - (k - 400) / 4;
            default: if (k <= 200) d = k / 4;
                     else if (k < 212) d = 255;
                     else d = 255 - (k - 208) / 4;
        endcase
        return d;
    endfunction

    // in_q[0] after edge base+k.
    function automatic logic exp_in(input int sc, input int k);
        logic v;
        case (sc)
            SC_UP:   v = (k >= 1);
            SC_REV:  v = (k >= 1 && k <= 400);
            default: v = (k >= 1 && k <= 210);
        endcase
        return v;
    endfunction

    task automatic push_fade(input int sc, input int base, input int j_lo, input int j_hi,
                             input string nm);
        int   d;
        logic l0;
        logic b;
        for (int j = j_lo; j <= j_hi; j++) begin
            d  = exp_duty(sc, j - 1);
            l0 = (d > ((j - 1) % 255));
            b  = (d != (exp_in(sc, j - 1) ? 255 : 0));
            push(base + j, {7'd0, l0}, b, nm);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Holds reset for n edges, expecting cleared outputs on each; leaves r_base
    // at the last reset edge. Must be called at time 0 or at a falling edge.
    task automatic do_reset(input int n, input logic [7:0] li, input logic e);
        int base;
        base   = cyc;
        rstn   = 1'b0;
        led_in = li;
        en     = e;
        for (int j = 1; j <= n; j++) push(base + j, 8'h00, 1'b0, "reset");
        repeat (n) @(negedge clk);
        rstn   = 1'b1;
        r_base = cyc;
    endtask

    initial begin
        int r;
        int ed;
        rstn   = 1'b0;
        led_in = 8'h00;
        en     = 1'b0;

        // Reset with all targets on, then instant switching.
        do_reset(3, 8'hFF, 1'b0);
        r      = r_base;
        led_in = 8'h00;
        en     = 1'b0;
        for (int j = 1; j <= 4; j++) push(r + j, 8'h00, 1'b0, "instant_idle");
        wait_cyc(r + 4);
        led_in = 8'hA5;
        ed     = r + 5;
        push(ed, 8'h00, 1'b0, "instant_edge");
        push(ed + 1, 8'h00, 1'b1, "instant_lat");
        for (int j = 2; j <= 300; j++) push(ed + j, 8'hA5, 1'b0, "instant_hold");
        wait_cyc(ed + 300);

        // Full fade up on channel 0.
        do_reset(3, 8'hFF, 1'b0);
        r      = r_base;
        led_in = 8'h01;
        en     = 1'b1;
        push_fade(SC_UP, r, 1, 1030, "fade_up");
        wait_cyc(r + 1030);

        // Ramp to 100, then reverse down to 0 and hold there.
        do_reset(2, 8'h00, 1'b1);
        r      = r_base;
        led_in = 8'h01;
        en     = 1'b1;
        push_fade(SC_REV, r, 1, 900, "reverse");
        wait_cyc(r + 400);
        led_in = 8'h00;
        wait_cyc(r + 900);

        // Snap at duty 50, resume a fade down, reset mid-fade, fade up again.
        do_reset(2, 8'h00, 1'b1);
        r      = r_base;
        led_in = 8'h01;
        en     = 1'b1;
        push_fade(SC_SW, r, 1, 239, "mode_switch");
        wait_cyc(r + 200);
        en     = 1'b0;
        wait_cyc(r + 210);
        en     = 1'b1;
        led_in = 8'h00;
        wait_cyc(r + 239);
        do_reset(1, 8'h01, 1'b1);
        r      = r_base;
        led_in = 8'h01;
        en     = 1'b1;
        push_fade(SC_UP, r, 1, 300, "restart");
        wait_cyc(r + 300);

        @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_breath_fader.md
LED_BREATH_FADER -- requirements
Module: led_breath_fader

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 97_656, meaning clk cycles per one-LSB duty step; legal range 1..2^24-1, giving a full 0->255 fade of about 24.9 M cycles at default.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port led_in, input, 8 bits: target on/off pattern from the upstream LED pattern generator, synchronous to clk.
REQ-005 The block SHALL have port en, input, 1 bit: 1 = fade enabled, 0 = instant switching.
REQ-006 The block SHALL have port led_out, output, 8 bits: PWM-dimmed LED drive, registered, 1 = LED on.
REQ-007 The block SHALL have port busy, output, 1 bit: registered, 1 while any channel's duty differs from its target.

Function
REQ-008 led_in SHALL be registered once into in_q; all further logic SHALL use in_q only.
REQ-009 Per channel i, the target SHALL be 255 when in_q[i]=1 and 0 when in_q[i]=0.
REQ-010 pwm_cnt (8-bit) SHALL count 0..254 and wrap to 0, giving a PWM period of 255 cycles.
REQ-011 step_cnt SHALL count 0..STEP_DIV-1 and wrap; step_tick SHALL be high for exactly the cycle where step_cnt==STEP_DIV-1.
REQ-012 With STEP_DIV=1, step_tick SHALL be high every cycle.
REQ-013 Each channel SHALL hold an 8-bit duty[i] register.
REQ-014 With en=1, duty[i] SHALL change only on cycles with step_tick=1, as follows:
- duty<target: +1
- duty>target: -1
- equal: hold
- duty SHALL never wrap past 0 or 255.
REQ-015 If in_q[i] changes mid-fade, duty[i] SHALL reverse direction from its current value on the next step_tick, with no jump.
REQ-016 With en=0, duty[i] SHALL load its target every cycle, regardless of step_tick.
REQ-017 led_out[i] SHALL be registered as (duty[i] > pwm_cnt). Consequences:
- duty 0: constantly 0
- duty 255: constantly 1
- duty d: d cycles high per 255-cycle period.
REQ-018 Latency with en=0 SHALL be as follows: led_in changes before edge E; in_q updates at E; duty at E+1; led_out settles (constant 0 or 1) at E+2.
REQ-019 busy SHALL be registered as the OR over i of (duty[i] != target[i]), evaluated on current duty and in_q; it lags duty by one cycle.
REQ-020 en SHALL take effect on the edge it is sampled.
REQ-021 en 1->0 mid-fade SHALL snap duty to target on the next edge; en 0->1 SHALL resume stepping from the current duty.
REQ-022 pwm_cnt and step_cnt SHALL run freely and SHALL NOT be reset or restarted by led_in or en changes.
REQ-023 All eight channels SHALL share pwm_cnt and step_tick; simultaneous changes on several channels SHALL fade in lockstep.

Reset
REQ-024 While rstn=0 at a clk edge, the following SHALL be cleared to 0: in_q, all duty[i], pwm_cnt, step_cnt, led_out and busy.
REQ-025 Reset asserted mid-fade SHALL abort the fade; after release, channels SHALL fade up from 0 toward in_q at the en=1 step rate.
REQ-026 No output SHALL be X after the first reset edge; no initial-value dependence is permitted.

Verification
REQ-027 Reset check: rstn=0 for 3 cycles with led_in=8'hFF -> led_out=8'h00 and busy=0 during reset.
REQ-028 Instant mode: STEP_DIV=4, en=0, led_in 8'h00->8'hA5 before edge E -> led_out=8'hA5 from E+2 onward, constant; busy stays 0 after E+2.
REQ-029 Fade up: STEP_DIV=4, en=1, led_in=8'h01 from reset -> duty[0] increments every 4 cycles and reaches 255 after 255 ticks (1020 cycles ±4). Expected along the way:
- led_out[0] high count per 255-cycle window equals duty[0]
- busy=1 throughout, then 0 one cycle after duty[0]=255
- led_out[7:1] stays 0.
REQ-030 Reversal: STEP_DIV=4, en=1, ramp channel 0 to duty 100, then led_in[0]=0 -> duty decrements from 100 with no jump, reaches 0 after 100 ticks, and never underflows.
REQ-031 Mode switch and reset mid-fade: at duty 50 with en=1, set en=0 -> duty[0]=255 next edge and led_out[0]=1 from the following edge. Then, with rstn=0 for 1 cycle while fading -> all duty=0; after release, fade restarts from 0.
